// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared op and state encodings for the iterative divider and its decode
package iter_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/universal_adder.sv
// rtl/universal_adder.sv - add/subtract unit; mode=1 computes a-b with carry=1 meaning no borrow
module universal_adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff        = mode ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring divider with RV32M div/divu/rem/remu semantics
// Define ITER_DIVIDER_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] result
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
`ifdef ITER_DIVIDER_EARLY_OUT_EN
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
`endif

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   div_q, div_d;
  logic [W-1:0]   result_q, result_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;

  logic           a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     partial, trial_diff;
  logic           trial_carry;
  logic [W-1:0]   quo_fix, rem_fix;
  logic           unused_msb;

  assign a_neg = op_is_signed(op) & dividend[W-1];
  assign b_neg = op_is_signed(op) & divisor[W-1];
  assign mag_a = a_neg ? (~dividend + ONE) : dividend;
  assign mag_b = b_neg ? (~divisor + ONE) : divisor;

  // Remainder/dividend pair shifted left by one; the top bit of the quotient
  // register feeds the remainder as the next dividend bit.
  assign partial = {rem_q, quo_q[W-1]};

  universal_adder #(
    .WIDTH (W + 1)
  ) u_trial (
    .a     (partial),
    .b     ({1'b0, div_q}),
    .mode  (1'b1),
    .sum   (trial_diff),
    .carry (trial_carry)
  );

  assign unused_msb = trial_diff[W] ^ partial[W];

  // A zero divisor yields all-ones magnitudes; force -1 so sign correction cannot flip it.
  assign quo_fix = div0_q ? {W{1'b1}} : (neg_quo_q ? (~quo_q + ONE) : quo_q);
  assign rem_fix = neg_rem_q ? (~rem_q + ONE) : rem_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          rem_d     = '0;
          quo_d     = mag_a;
          div_d     = mag_b;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (divisor == '0);
          cnt_d     = CW'(W - 1);
          state_d   = S_CALC;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
          if (divisor == '0) begin
            result_d = op_is_rem(op) ? dividend : {W{1'b1}};
            cnt_d    = '0;
            state_d  = S_DONE;
          end else if (op_is_signed(op) && dividend == MIN_NEG && divisor == {W{1'b1}}) begin
            result_d = op_is_rem(op) ? '0 : dividend;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        quo_d = {quo_q[W-2:0], trial_carry};
        rem_d = trial_carry ? trial_diff[W-1:0] : partial[W-1:0];
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for iter_divider (either ITER_DIVIDER_EARLY_OUT_EN build)
module tb_iter_divider;
  import iter_divider_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  iter_divider #(.DATAWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         sgn;
    sgn = ~o[0];
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    logic special;
    special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef ITER_DIVIDER_EARLY_OUT_EN
    return special ? 1 : W + 2;
`else
    return special ? W + 2 : W + 2;
`endif
  endfunction

  // Presents one request for a single cycle, then scrambles the operands.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, output bit acc);
    exp_t e;
    @(negedge clk);
    acc      = in_ready;
    op       = o;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    if (track) begin
      e.res = model_res(o, a, b);
      e.lat = model_lat(o, a, b);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Latency counts the accepting cycle as cycle 0.
  task automatic collect(output logic [W-1:0] r, output int lat, output bit ok);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid;
    r  = result;
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [1:0]   ops[2];
    logic [W-1:0] r;
    int           lat;
    bit           ok, acc;
    exp_t         e;
    ops[0] = OP_DIVU;
    ops[1] = OP_REMU;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 32'd100, 32'd7, 1'b1, acc);
      collect(r, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!acc) begin errors++; $display("FAIL unsigned_accept[%0d] got in_ready 0 want 1", i); end
      checks++;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL unsigned_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (r !== e.res) begin errors++; $display("FAIL unsigned_result[%0d] got %h want %h", i, r, e.res); end
      release_out();
    end
  endtask

  task automatic test_signed;
    logic [1:0]   ops[3];
    logic [W-1:0] as[3];
    logic [W-1:0] bs[3];
    logic [W-1:0] r;
    int           lat;
    bit           ok, acc;
    exp_t         e;
    ops[0] = OP_DIV; as[0] = -32'sd7; bs[0] = 32'd2;
    ops[1] = OP_REM; as[1] = -32'sd7; bs[1] = 32'd2;
    ops[2] = OP_REM; as[2] = 32'd7;   bs[2] = -32'sd2;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1, acc);
      collect(r, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL signed_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (r !== e.res) begin errors++; $display("FAIL signed_result[%0d] got %h want %h", i, r, e.res); end
      release_out();
    end
  endtask

  task automatic test_corner;
    logic [1:0]   ops[6];
    logic [W-1:0] as[6];
    logic [W-1:0] bs[6];
    logic [W-1:0] r;
    int           lat;
    bit           ok, acc;
    exp_t         e;
    ops[0] = OP_DIV;  as[0] = 32'h8000_0000; bs[0] = 32'hFFFF_FFFF;
    ops[1] = OP_REM;  as[1] = 32'h8000_0000; bs[1] = 32'hFFFF_FFFF;
    ops[2] = OP_DIV;  as[2] = 32'd5;         bs[2] = 32'd0;
    ops[3] = OP_REM;  as[3] = 32'd5;         bs[3] = 32'd0;
    ops[4] = OP_DIV;  as[4] = -32'sd5;       bs[4] = 32'd0;
    ops[5] = OP_REMU; as[5] = 32'hDEAD_BEEF; bs[5] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1, acc);
      collect(r, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL corner_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (r !== e.res) begin errors++; $display("FAIL corner_result[%0d] got %h want %h", i, r, e.res); end
      release_out();
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] r;
    int           lat;
    bit           ok, acc;
    exp_t         e;
    issue(OP_DIVU, 32'd1000, 32'd10, 1'b1, acc);
    collect(r, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || r !== e.res) begin errors++; $display("FAIL stall_first got %h want %h", r, e.res); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = 32'd3;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b r=%h rdy=%b want v=1 r=%h rdy=0",
                 i, out_valid, result, in_ready, e.res);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush;
    logic [W-1:0] r;
    int           lat;
    bit           ok, acc, seen;
    exp_t         e;
    issue(OP_DIVU, 32'hFFFF_0000, 32'd3, 1'b0, acc);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_output got out_valid 1 want 0"); end
    issue(OP_DIVU, 32'd9, 32'd3, 1'b1, acc);
    collect(r, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat !== e.lat || r !== e.res) begin
      errors++;
      $display("FAIL flush_recover got r=%h lat=%0d want r=%h lat=%0d", r, lat, e.res, e.lat);
    end
    release_out();
  endtask

  task automatic test_rst_mid;
    bit acc;
    issue(OP_DIV, 32'd12345, 32'd7, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b v=%b r=%h want rdy=1 v=0 r=0", in_ready, out_valid, result);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]   o;
    logic [W-1:0] a, b, r;
    int           lat;
    bit           ok, acc;
    exp_t         e;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case (i % 4)
        0: b = '0;
        1: b = 32'($urandom_range(1, 255));
        2: b = -32'sd1;
        default: b = $urandom;
      endcase
      if (i == 6) a = 32'h8000_0000;
      issue(o, a, b, 1'b1, acc);
      collect(r, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!acc || !ok || lat !== e.lat || r !== e.res) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h got r=%h lat=%0d want r=%h lat=%0d",
                 i, o, a, b, r, lat, e.res, e.lat);
      end
      release_out();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_stall();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  divider can accept request.
REQ-006 SHALL have port op  input  2  00 div, 01 divu, 10 rem, 11 remu (RV32M semantics).
REQ-007 SHALL have ports dividend, divisor  input  DATAWIDTH  operands, sampled on acceptance.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  DATAWIDTH  quotient or remainder per op.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL accept when in_valid&&in_ready: latch op, operand magnitudes (abs for signed ops), result signs; IDLE->CALC, iteration counter=DATAWIDTH-1.
REQ-014 SHALL in CALC perform one restoring step per cycle: shift remainder/dividend pair left 1, trial-subtract divisor magnitude; carry-out=1 -> keep difference, quotient bit 1; else restore, bit 0.
REQ-015 SHALL leave CALC after exactly DATAWIDTH steps (counter 0) for FIX; FIX applies sign correction (quotient negative iff operand signs differ, remainder takes dividend sign), then DONE.
REQ-016 SHALL assert out_valid exactly DATAWIDTH+2 cycles after the accepting edge (early-out excluded, REQ-024).
REQ-017 SHALL hold result and out_valid stable in DONE until out_ready=1; on that edge go to IDLE (no same-cycle re-accept; in_ready rises next cycle).
REQ-018 SHALL on divisor==0 return quotient all-ones and remainder=dividend, for signed and unsigned ops.
REQ-019 SHALL on signed overflow (dividend=-2^(DATAWIDTH-1), divisor=-1) return quotient=dividend, remainder=0.
REQ-020 SHALL on flush=1 in any state go to IDLE next cycle, drop out_valid, discard result; flush has priority over accept and out_ready.
REQ-021 SHALL ignore operand/op changes after acceptance; in_valid while busy has no effect.

Reset
REQ-022 SHALL on rst=1 at a clock edge enter IDLE; in_ready=1, out_valid=0, result=0, counter=0, mid-operation included; rst overrides flush.

Configuration
REQ-023 SHALL compile early-out only under macro ITER_DIVIDER_EARLY_OUT_EN.
REQ-024 SHALL with ITER_DIVIDER_EARLY_OUT_EN defined route divide-by-zero and signed-overflow requests IDLE->DONE, out_valid exactly 1 cycle after acceptance; without it every request takes DATAWIDTH+2 cycles; results identical in both builds.

Structure
REQ-025 SHALL place op encodings (DIV/DIVU/REM/REMU) and state encodings in shared header div_defs.vh, also used by decode.
REQ-026 SHALL instantiate existing universal_adder (DATAWIDTH+1 bits, mode=1) for trial subtraction, using its carry as non-negative flag; negation in FIX may reuse it via a mux or a local subtract.

Verification
REQ-027 SHALL cover divu 100/7 -> result 14 on out_valid at cycle 34 after accept (W=32); remu 100/7 -> 2.
REQ-028 SHALL cover div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1); rem 7/-2 -> 1.
REQ-029 SHALL cover div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0; div 5/0 -> 0xFFFFFFFF, rem 5/0 -> 5; both builds, 1-cycle latency with macro.
REQ-030 SHALL cover out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready=0 throughout.
REQ-031 SHALL cover flush at CALC step 10 -> IDLE next cycle, no out_valid; next request divu 9/3 -> 3 correct.
REQ-032 SHALL cover rst pulse mid-CALC -> in_ready=1, out_valid=0, result=0 cycle after reset edge.
